// File: rtl/imem_loader_pkg.sv
// Shared constants, FSM state encoding and helpers for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W    = 12;
  localparam int unsigned IMEM_DEPTH     = 1 << IMEM_ADDR_W;
  localparam int unsigned IMEM_DATA_W    = 32;
  localparam int unsigned HDR_LEN        = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned COUNT_W        = 16;

  // All-zero word decodes as add r0,r0,r0: a harmless no-op for a runaway PC.
  localparam logic [IMEM_DATA_W-1:0] NOP_INSN = '0;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  function automatic logic count_exceeds(input logic [COUNT_W-1:0] n,
                                         input int unsigned depth);
    return {16'b0, n} > depth;
  endfunction

endpackage

// File: rtl/imem_store.sv
// Instruction store: one synchronous write port, one zero-latency read port.
module imem_store
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch on purpose; clearing thousands of
  // words would turn it into flops. Stale words are masked by the loader.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Receives a program image over a byte stream, verifies its XOR checksum,
// then releases the processor and serves its instruction fetches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] address_imem,
  output logic [DATA_W-1:0] q_imem,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  state_e               state_q;
  logic [COUNT_W-1:0]   n_q;
  logic [ADDR_W:0]      word_idx_q;
  logic [1:0]           byte_cnt_q;
  logic [DATA_W-9:0]    asm_q;
  logic [7:0]           xor_q;
  logic                 cpu_reset_q;
  logic                 load_done_q;
  logic                 load_error_q;

  logic                 accept;
  logic                 last_byte;
  logic                 last_word;
  logic [COUNT_W-1:0]   n_full;
  logic [COUNT_W-1:0]   word_idx_ext;
  logic [COUNT_W-1:0]   fetch_ext;
  logic                 store_we;
  logic [DATA_W-1:0]    store_wdata;
  logic [DATA_W-1:0]    store_rdata;

  assign rx_ready = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                    (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign accept   = rx_valid && rx_ready;

  assign n_full       = {n_q[15:8], rx_byte};
  assign word_idx_ext = {{(COUNT_W-ADDR_W-1){1'b0}}, word_idx_q};
  assign fetch_ext    = {{(COUNT_W-ADDR_W){1'b0}}, address_imem};
  assign last_byte    = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
  assign last_word    = (word_idx_ext == n_q - 16'd1);

  // The word is written on the same edge that accepts its final byte.
  assign store_we    = accept && (state_q == ST_DATA) && last_byte;
  assign store_wdata = {asm_q, rx_byte};

  imem_store #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_store (
    .clock   (clock),
    .we_i    (store_we),
    .waddr_i (word_idx_q[ADDR_W-1:0]),
    .wdata_i (store_wdata),
    .raddr_i (address_imem),
    .rdata_o (store_rdata)
  );

  // NOTE: state lives only in always_ff with non-blocking assignments, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_HDR_HI;
      n_q          <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      xor_q        <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else if (accept) begin
      case (state_q)
        ST_HDR_HI: begin
          n_q[15:8] <= rx_byte;
          state_q   <= ST_HDR_LO;
        end
        ST_HDR_LO: begin
          n_q[7:0] <= rx_byte;
          if (count_exceeds(n_full, DEPTH)) begin
            state_q      <= ST_ERR;
            load_error_q <= 1'b1;
          end else if (n_full == '0) begin
            state_q <= ST_CSUM;
          end else begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          asm_q      <= {asm_q[DATA_W-17:0], rx_byte};
          xor_q      <= xor_q ^ rx_byte;
          byte_cnt_q <= 2'(byte_cnt_q + 2'd1);
          if (last_byte) begin
            word_idx_q <= word_idx_q + 1'b1;
            if (last_word) begin
              state_q <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (rx_byte == xor_q) begin
            state_q     <= ST_RUN;
            cpu_reset_q <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            state_q      <= ST_ERR;
            load_error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    q_imem = DATA_W'(NOP_INSN);
    if ((state_q == ST_RUN) && (fetch_ext < n_q)) begin
      q_imem = store_rdata;
    end
  end

  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboarded store writes plus
// status and fetch checks over good, bad, empty, oversize and interrupted loads.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_ready;
  logic [ADDR_W-1:0] address_imem;
  logic [DATA_W-1:0] q_imem;
  logic              cpu_reset;
  logic              load_done;
  logic              load_error;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  imem_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_ready     (rx_ready),
    .address_imem (address_imem),
    .q_imem       (q_imem),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Streams an image; each completed payload word is pushed to the scoreboard
  // and must be visible in the store right after its 4th byte is accepted.
  task automatic load_image(input logic [7:0] img[$], input int max_gap);
    int  n;
    int  gap;
    bit  pushed;
    wr_t w;
    n = (img.size() >= 2) ? int'({img[0], img[1]}) : 0;
    for (int i = 0; i < img.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        tick();
      end
      rx_valid = 1'b1;
      rx_byte  = img[i];
      checks++;
      if (rx_ready !== 1'b1) begin
        errors++;
        $display("FAIL rx_ready_byte%0d: got %b want 1", i, rx_ready);
      end
      if (i == img.size() - 1) begin
        checks++;
        if ({cpu_reset, load_done, load_error} !== 3'b100) begin
          errors++;
          $display("FAIL pre_final_status: got %b want 100",
                   {cpu_reset, load_done, load_error});
        end
      end
      pushed = 1'b0;
      if (n <= DEPTH && i >= HDR_LEN && i < HDR_LEN + BYTES_PER_WORD * n &&
          ((i - HDR_LEN) % BYTES_PER_WORD) == BYTES_PER_WORD - 1) begin
        w.addr = ADDR_W'((i - HDR_LEN) / BYTES_PER_WORD);
        w.data = {img[i-3], img[i-2], img[i-1], img[i]};
        sb.push_back(w);
        pushed = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      if (pushed) begin
        w = sb.pop_front();
        checks++;
        if (dut.u_store.mem[w.addr] !== w.data) begin
          errors++;
          $display("FAIL store_word%0d: got %h want %h", w.addr,
                   dut.u_store.mem[w.addr], w.data);
        end
      end
    end
  endtask

  function automatic void build_image(input logic [31:0] words[$],
                                      input logic [7:0] csum_flip,
                                      output logic [7:0] img[$]);
    logic [7:0] x;
    logic [15:0] n;
    x = 8'h00;
    n = 16'(words.size());
    img = {};
    img.push_back(n[15:8]);
    img.push_back(n[7:0]);
    foreach (words[k]) begin
      for (int b = 3; b >= 0; b--) begin
        img.push_back(words[k][b*8 +: 8]);
        x ^= words[k][b*8 +: 8];
      end
    end
    img.push_back(x ^ csum_flip);
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_status: got %b want 1100",
               {rx_ready, cpu_reset, load_done, load_error});
    end
    address_imem = '0;
    #1;
    checks++;
    if (q_imem !== 32'h0) begin
      errors++;
      $display("FAIL reset_q: got %h want 0", q_imem);
    end
  endtask

  task automatic test_good_load();
    logic [7:0] img[$];
    logic [31:0] exp_q[3];
    img = '{8'h00, 8'h02, 8'h28, 8'h00, 8'h00, 8'h05,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    exp_q = '{32'h28000005, 32'h0, 32'h0};
    apply_reset();
    load_image(img, 0);
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b0010) begin
      errors++;
      $display("FAIL good_status: got %b want 0010",
               {rx_ready, cpu_reset, load_done, load_error});
    end
    for (int a = 0; a < 3; a++) begin
      address_imem = ADDR_W'(a);
      #1;
      checks++;
      if (q_imem !== exp_q[a]) begin
        errors++;
        $display("FAIL good_q%0d: got %h want %h", a, q_imem, exp_q[a]);
      end
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] img[$];
    img = '{8'h00, 8'h02, 8'h28, 8'h00, 8'h00, 8'h05,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h2C};
    apply_reset();
    load_image(img, 0);
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b0101) begin
      errors++;
      $display("FAIL badcsum_status: got %b want 0101",
               {rx_ready, cpu_reset, load_done, load_error});
    end
    for (int a = 0; a < 3; a++) begin
      address_imem = ADDR_W'(a);
      #1;
      checks++;
      if (q_imem !== 32'h0) begin
        errors++;
        $display("FAIL badcsum_q%0d: got %h want 0", a, q_imem);
      end
    end
  endtask

  task automatic test_oversize();
    logic [7:0] img[$];
    apply_reset();
    img = '{8'h10, 8'h01};
    load_image(img, 0);
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b0101) begin
      errors++;
      $display("FAIL oversize_status: got %b want 0101",
               {rx_ready, cpu_reset, load_done, load_error});
    end
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_byte  = 8'(8'hA0 + i);
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL oversize_ready%0d: got %b want 0", i, rx_ready);
      end
      tick();
    end
    rx_valid = 1'b0;
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b0101) begin
      errors++;
      $display("FAIL oversize_sticky: got %b want 0101",
               {rx_ready, cpu_reset, load_done, load_error});
    end
    // N == DEPTH exactly is legal and must keep loading.
    apply_reset();
    img = '{8'h10, 8'h00};
    load_image(img, 0);
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b1100) begin
      errors++;
      $display("FAIL depth_boundary: got %b want 1100",
               {rx_ready, cpu_reset, load_done, load_error});
    end
  endtask

  task automatic test_zero();
    logic [7:0] img[$];
    apply_reset();
    img = '{8'h00, 8'h00, 8'h00};
    load_image(img, 0);
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b0010) begin
      errors++;
      $display("FAIL zero_status: got %b want 0010",
               {rx_ready, cpu_reset, load_done, load_error});
    end
    address_imem = '0;
    #1;
    checks++;
    if (q_imem !== 32'h0) begin
      errors++;
      $display("FAIL zero_q0: got %h want 0", q_imem);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] w1[$];
    logic [31:0] w2[$];
    logic [7:0]  img[$];
    for (int k = 0; k < 16; k++) begin
      w1.push_back($urandom | 32'h1);
      w2.push_back($urandom | 32'h100);
    end
    apply_reset();
    build_image(w1, 8'h00, img);
    load_image(img, 0);
    apply_reset();
    build_image(w2, 8'h00, img);
    load_image(img, 5);
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b0010) begin
      errors++;
      $display("FAIL gaps_status: got %b want 0010",
               {rx_ready, cpu_reset, load_done, load_error});
    end
    for (int a = 0; a <= 16; a++) begin
      address_imem = ADDR_W'(a);
      #1;
      checks++;
      if (q_imem !== ((a < 16) ? w2[a] : 32'h0)) begin
        errors++;
        $display("FAIL gaps_q%0d: got %h want %h", a, q_imem,
                 (a < 16) ? w2[a] : 32'h0);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] img[$];
    apply_reset();
    img = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load_image(img, 0);
    apply_reset();
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b1100) begin
      errors++;
      $display("FAIL midreset_status: got %b want 1100",
               {rx_ready, cpu_reset, load_done, load_error});
    end
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    load_image(img, 0);
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_run: got %b want 0010",
               {rx_ready, cpu_reset, load_done, load_error});
    end
    address_imem = '0;
    #1;
    checks++;
    if (q_imem !== 32'h12345678) begin
      errors++;
      $display("FAIL midreset_q0: got %h want 12345678", q_imem);
    end
    address_imem = ADDR_W'(1);
    #1;
    checks++;
    if (q_imem !== 32'h0) begin
      errors++;
      $display("FAIL midreset_q1: got %h want 0", q_imem);
    end
  endtask

  task automatic test_reset_in_run();
    reset = 1'b1;
    tick();
    checks++;
    if ({rx_ready, cpu_reset, load_done, load_error} !== 4'b1100) begin
      errors++;
      $display("FAIL runreset_status: got %b want 1100",
               {rx_ready, cpu_reset, load_done, load_error});
    end
    address_imem = '0;
    #1;
    checks++;
    if (q_imem !== 32'h0) begin
      errors++;
      $display("FAIL runreset_q0: got %h want 0", q_imem);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    rx_valid     = 1'b0;
    rx_byte      = 8'h00;
    address_imem = '0;
    test_reset();
    test_good_load();
    test_bad_csum();
    test_oversize();
    test_zero();
    test_gaps();
    test_mid_reset();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
